pc_gen: RTL and testbench
=========================

// Module: pc_gen
// PURPOSE
// - IF-stage program-counter generator; consumes the branch redirect (branch_flag/branch_addr) resolved in ID.
// - Drives the instruction-ROM fetch address and enable.
// - Holds a one-entry pending-redirect buffer, so a redirect raised while IF is stalled but ID advances is not lost.
// - Sits between the ID-stage branch resolver and the instruction ROM interface.
// PARAMETERS
// - RESET_PC  32'hBFC0_0000  fetch address loaded on reset
// - PC_STEP   4              sequential increment in bytes
// PORTS
// - clk          in   1   core clock, all state updates on rising edge
// - rst          in   1   synchronous, active-high reset
// - stall_pc     in   1   hold PC (ROM not ready / hazard), IF-only stall
// - flush        in   1   exception/eret redirect request
// - flush_pc     in   32  redirect target when flush=1
// - branch_flag  in   1   taken branch/jump from ID this cycle
// - branch_addr  in   32  redirect target when branch_flag=1
// - pc           out  32  current fetch address (registered)
// - rom_en       out  1   ROM fetch enable (registered)
// - pend_valid   out  1   pending redirect held (debug/perf visibility)
// - fetch_adel   out  1   fetch address misaligned (see CONFIGURATION)
// BEHAVIOUR
// - Reset (rst=1 at edge): pc=RESET_PC, rom_en=0, pend_valid=0, pend_addr=0, fetch_adel=0, state=RUN.
// - First edge after rst deasserts: rom_en=1, pc stays RESET_PC; fetch sequencing begins the following edge.
// - FSM states: RUN (no pending redirect), PEND (pend_addr valid).
// - Per-edge priority, highest first: rst > flush > stall_pc > live branch > pending > sequential.
//   - flush=1: pc<=flush_pc, pending cleared, state->RUN. Applies regardless of stall_pc.
//   - stall_pc=1, branch_flag=1: pc held; pend_addr<=branch_addr; state->PEND.
//     - If already PEND, the newer address overwrites.
//   - stall_pc=1, branch_flag=0: pc and pending unchanged.
//   - stall_pc=0, branch_flag=1: pc<=branch_addr; pending cleared (live redirect wins); state->RUN.
//   - stall_pc=0, PEND, branch_flag=0: pc<=pend_addr; state->RUN.
//   - Otherwise: pc<=pc+PC_STEP, modulo 2^32. 32'hFFFF_FFFC wraps to 0, with no flag.
// - Latency:
//   - Redirect visible on pc one edge after an unstalled branch_flag.
//   - For a stalled branch_flag: one edge after the first unstalled cycle.
// - Delay slot: the instruction fetched in the cycle branch_flag is high is the delay slot. pc_gen never squashes it.
// - pend_valid = (state==PEND), registered.
// - rst asserted mid-PEND discards the pending redirect.
// - rom_en stays 1 during stall; the ROM re-reads the held pc.
// CONFIGURATION
// - Macro PC_ALIGN_CHECK_EN, when defined:
//   - On every pc load, fetch_adel<=(next_pc[1:0]!=0).
//   - rom_en<=~fetch_adel for that address, so the ROM is not accessed.
//   - pc is still loaded with the misaligned value, for EPC/BadVAddr.
//   - Cleared on the next aligned load or on flush.
// - Macro PC_ALIGN_CHECK_EN, when not defined:
//   - fetch_adel tied 0.
//   - Low address bits passed to pc unchanged.
// STRUCTURE
// - Shared header pc.v:
//   - `RESET_PC_VAL
//   - `PC_STATE_RUN / `PC_STATE_PEND (1-bit encodings)
//   - reuse `ADDR_BUS from bus.v for all 32-bit ports
// - Sub-module branch_pend_buf:
//   - One-entry capture/release buffer (valid + addr).
//   - Inputs: capture, release, clear.
// - pc_gen keeps the PC register, the priority mux and the optional alignment check.
// TESTING
// - Reset: hold rst 3 cycles -> pc=BFC00000, rom_en=0. Release rst -> rom_en=1, then pc=BFC00004 on the next edge.
// - Branch at pc=BFC00010, branch_flag=1 with addr=BFC00100, no stall -> pc=BFC00100 next edge (no intermediate BFC00014 step).
// - Stalled capture: stall_pc=1, branch_flag=1 addr=80000040 for one cycle, stall held 2 more cycles:
//   - pend_valid=1, pc held.
//   - Stall drops -> pc=80000040, pend_valid=0.
// - Flush over stall and pending: state PEND, stall_pc=1, flush=1 with flush_pc=BFC00380 -> pc=BFC00380, pend_valid=0.
// - Wrap: force pc=FFFFFFFC, no events -> pc=00000000 next edge.
// - Alignment (PC_ALIGN_CHECK_EN defined): branch_addr=80000042:
//   - pc=80000042, fetch_adel=1, rom_en=0.
//   - Then flush to BFC00380 -> fetch_adel=0, rom_en=1.
//   - With the macro undefined, fetch_adel stays 0.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// Shared constants and state encoding for the IF-stage PC generator.
// Optional alignment check: define PC_ALIGN_CHECK_EN.
package pc_gen_pkg;

  localparam logic [31:0] RESET_PC_VAL = 32'hBFC0_0000;
  localparam logic [31:0] PC_STEP_VAL  = 32'd4;

  typedef enum logic {
    PC_STATE_RUN  = 1'b0,
    PC_STATE_PEND = 1'b1
  } pc_state_t;

endpackage

// File: rtl/branch_pend_buf.sv
// One-entry redirect buffer: captures a branch target while IF is
// stalled and releases it once fetch can advance.
module branch_pend_buf
  import pc_gen_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_capture,
  input  logic        i_release,
  input  logic        i_clear,
  input  logic [31:0] i_addr,
  output logic        o_valid,
  output logic [31:0] o_addr
);

  pc_state_t   r_state;
  logic [31:0] r_addr;

  // Capture overwrites any older entry; clear beats everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= PC_STATE_RUN;
      r_addr  <= '0;
    end else if (i_clear) begin
      r_state <= PC_STATE_RUN;
    end else if (i_capture) begin
      r_state <= PC_STATE_PEND;
      r_addr  <= i_addr;
    end else if (i_release) begin
      r_state <= PC_STATE_RUN;
    end
  end

  assign o_valid = (r_state == PC_STATE_PEND);
  assign o_addr  = r_addr;

endmodule

// File: rtl/pc_gen.sv
// IF-stage program counter with pending-redirect buffer.
// Optional misaligned-fetch detection: define PC_ALIGN_CHECK_EN.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_VAL,
  parameter logic [31:0] PC_STEP  = PC_STEP_VAL
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_pc,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        branch_flag,
  input  logic [31:0] branch_addr,
  output logic [31:0] pc,
  output logic        rom_en,
  output logic        pend_valid,
  output logic        fetch_adel
);

  logic [31:0] r_pc;
  logic        r_rom_en;
  logic        r_boot;
  logic        w_active;
  logic        w_pend_valid;
  logic [31:0] w_pend_addr;
  logic        w_capture;
  logic        w_release;
  logic        w_clear;
  logic        w_load;
  logic [31:0] w_next_pc;

  // Fetch only advances once the post-reset enable cycle is done.
  assign w_active  = ~r_boot;
  assign w_capture = w_active & ~flush & stall_pc & branch_flag;
  assign w_release = w_active & ~flush & ~stall_pc & ~branch_flag;
  assign w_clear   = w_active & (flush | (~stall_pc & branch_flag));

  branch_pend_buf u_pend (
    .clk       (clk),
    .rst       (rst),
    .i_capture (w_capture),
    .i_release (w_release),
    .i_clear   (w_clear),
    .i_addr    (branch_addr),
    .o_valid   (w_pend_valid),
    .o_addr    (w_pend_addr)
  );

  // Redirect priority: flush, stall, live branch, pending, step.
  always_comb begin
    w_load    = 1'b0;
    w_next_pc = r_pc;
    if (w_active) begin
      if (flush) begin
        w_load    = 1'b1;
        w_next_pc = flush_pc;
      end else if (stall_pc) begin
        w_load    = 1'b0;
      end else if (branch_flag) begin
        w_load    = 1'b1;
        w_next_pc = branch_addr;
      end else if (w_pend_valid) begin
        w_load    = 1'b1;
        w_next_pc = w_pend_addr;
      end else begin
        w_load    = 1'b1;
        w_next_pc = r_pc + PC_STEP;
      end
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  logic r_adel;
  logic w_mis;

  assign w_mis = (w_next_pc[1:0] != 2'b00);

  // PC, enable and misalignment flag; ROM is gated off a bad address.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc     <= RESET_PC;
      r_rom_en <= 1'b0;
      r_boot   <= 1'b1;
      r_adel   <= 1'b0;
    end else if (r_boot) begin
      r_boot   <= 1'b0;
      r_rom_en <= 1'b1;
    end else if (w_load) begin
      r_pc     <= w_next_pc;
      r_adel   <= w_mis;
      r_rom_en <= ~w_mis;
    end
  end

  assign fetch_adel = r_adel;
`else
  // PC and enable; low address bits pass through untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc     <= RESET_PC;
      r_rom_en <= 1'b0;
      r_boot   <= 1'b1;
    end else if (r_boot) begin
      r_boot   <= 1'b0;
      r_rom_en <= 1'b1;
    end else if (w_load) begin
      r_pc     <= w_next_pc;
      r_rom_en <= 1'b1;
    end
  end

  assign fetch_adel = 1'b0;
`endif

  assign pc         = r_pc;
  assign rom_en     = r_rom_en;
  assign pend_valid = w_pend_valid;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed table, corner
// sequences and randomized traffic against a reference model.
module tb_pc_gen;

  logic        clk;
  logic        rst;
  logic        stall_pc;
  logic        flush;
  logic [31:0] flush_pc;
  logic        branch_flag;
  logic [31:0] branch_addr;
  logic [31:0] pc;
  logic        rom_en;
  logic        pend_valid;
  logic        fetch_adel;

  int checks = 0;
  int errors = 0;

  pc_gen dut (
    .clk         (clk),
    .rst         (rst),
    .stall_pc    (stall_pc),
    .flush       (flush),
    .flush_pc    (flush_pc),
    .branch_flag (branch_flag),
    .branch_addr (branch_addr),
    .pc          (pc),
    .rom_en      (rom_en),
    .pend_valid  (pend_valid),
    .fetch_adel  (fetch_adel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic [31:0] m_pc;
  logic        m_rom;
  logic        m_pv;
  logic [31:0] m_pa;
  logic        m_adel;
  logic        m_boot;

  task automatic model_edge(input logic r, input logic s,
                            input logic f, input logic [31:0] fp,
                            input logic b, input logic [31:0] ba);
    logic        ld;
    logic [31:0] nx;
    logic [31:0] lo;
    ld = 1'b0;
    nx = m_pc;
    if (r) begin
      m_pc = 32'hBFC0_0000; m_rom = 0; m_pv = 0;
      m_pa = 0; m_adel = 0; m_boot = 1;
    end else if (m_boot) begin
      m_boot = 0;
      m_rom  = 1;
    end else begin
      if (f) begin
        nx = fp; ld = 1; m_pv = 0;
      end else if (s) begin
        if (b) begin
          m_pv = 1; m_pa = ba;
        end
      end else if (b) begin
        nx = ba; ld = 1; m_pv = 0;
      end else if (m_pv) begin
        nx = m_pa; ld = 1; m_pv = 0;
      end else begin
        nx = m_pc + 32'd4; ld = 1;
      end
      if (ld) begin
        m_pc = nx;
        lo   = nx % 4;
`ifdef PC_ALIGN_CHECK_EN
        m_adel = (lo != 0);
`else
        m_adel = 1'b0;
`endif
        m_rom = ~m_adel;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic f,
                      input logic [31:0] fp, input logic b,
                      input logic [31:0] ba);
    @(negedge clk);
    rst = r; stall_pc = s; flush = f;
    flush_pc = fp; branch_flag = b; branch_addr = ba;
    @(posedge clk);
    model_edge(r, s, f, fp, b, ba);
    #1;
  endtask

  typedef struct {
    logic        r, s, f;
    logic [31:0] fp;
    logic        b;
    logic [31:0] ba;
    logic [31:0] e_pc;
    logic        e_rom, e_pv;
  } vec_t;

  function automatic vec_t mk(logic r, logic s, logic f,
                              logic [31:0] fp, logic b,
                              logic [31:0] ba, logic [31:0] ep,
                              logic er, logic ev);
    vec_t v;
    v.r = r; v.s = s; v.f = f; v.fp = fp; v.b = b; v.ba = ba;
    v.e_pc = ep; v.e_rom = er; v.e_pv = ev;
    return v;
  endfunction

  vec_t tbl[28];

  initial begin
    rst = 1; stall_pc = 0; flush = 0; flush_pc = 0;
    branch_flag = 0; branch_addr = 0;
    m_pc = 0; m_rom = 0; m_pv = 0; m_pa = 0; m_adel = 0; m_boot = 1;

    tbl[0]  = mk(1,0,0,0,0,0,32'hBFC00000,0,0);
    tbl[1]  = mk(1,0,0,0,0,0,32'hBFC00000,0,0);
    tbl[2]  = mk(1,0,0,0,0,0,32'hBFC00000,0,0);
    tbl[3]  = mk(0,0,0,0,0,0,32'hBFC00000,1,0);
    tbl[4]  = mk(0,0,0,0,0,0,32'hBFC00004,1,0);
    tbl[5]  = mk(0,0,0,0,0,0,32'hBFC00008,1,0);
    tbl[6]  = mk(0,0,0,0,0,0,32'hBFC0000C,1,0);
    tbl[7]  = mk(0,0,0,0,0,0,32'hBFC00010,1,0);
    tbl[8]  = mk(0,0,0,0,1,32'hBFC00100,32'hBFC00100,1,0);
    tbl[9]  = mk(0,1,0,0,1,32'h80000040,32'hBFC00100,1,1);
    tbl[10] = mk(0,1,0,0,0,0,32'hBFC00100,1,1);
    tbl[11] = mk(0,1,0,0,0,0,32'hBFC00100,1,1);
    tbl[12] = mk(0,0,0,0,0,0,32'h80000040,1,0);
    tbl[13] = mk(0,0,0,0,0,0,32'h80000044,1,0);
    tbl[14] = mk(0,1,0,0,1,32'h12345678,32'h80000044,1,1);
    tbl[15] = mk(0,1,1,32'hBFC00380,0,0,32'hBFC00380,1,0);
    tbl[16] = mk(0,0,0,0,0,0,32'hBFC00384,1,0);
    tbl[17] = mk(0,0,0,0,1,32'hFFFFFFFC,32'hFFFFFFFC,1,0);
    tbl[18] = mk(0,0,0,0,0,0,32'h00000000,1,0);
    tbl[19] = mk(0,0,0,0,0,0,32'h00000004,1,0);
    tbl[20] = mk(0,1,0,0,1,32'h100,32'h00000004,1,1);
    tbl[21] = mk(0,1,0,0,1,32'h200,32'h00000004,1,1);
    tbl[22] = mk(0,0,0,0,1,32'h300,32'h00000300,1,0);
    tbl[23] = mk(0,0,0,0,0,0,32'h00000304,1,0);
    tbl[24] = mk(0,1,0,0,1,32'h500,32'h00000304,1,1);
    tbl[25] = mk(1,0,0,0,0,0,32'hBFC00000,0,0);
    tbl[26] = mk(0,0,0,0,0,0,32'hBFC00000,1,0);
    tbl[27] = mk(0,0,0,0,0,0,32'hBFC00004,1,0);

    for (int i = 0; i < 28; i++) begin
      step(tbl[i].r, tbl[i].s, tbl[i].f, tbl[i].fp,
           tbl[i].b, tbl[i].ba);
      chk($sformatf("tbl%0d pc", i), pc, tbl[i].e_pc);
      chk($sformatf("tbl%0d rom_en", i), 32'(rom_en),
          32'(tbl[i].e_rom));
      chk($sformatf("tbl%0d pend", i), 32'(pend_valid),
          32'(tbl[i].e_pv));
      chk($sformatf("tbl%0d adel", i), 32'(fetch_adel), 32'd0);
    end

    // misaligned branch target, then flush back to aligned
    step(0,0,0,0,1,32'h80000042);
    chk("align pc", pc, 32'h80000042);
`ifdef PC_ALIGN_CHECK_EN
    chk("align adel", 32'(fetch_adel), 32'd1);
    chk("align rom_en", 32'(rom_en), 32'd0);
`else
    chk("align adel", 32'(fetch_adel), 32'd0);
    chk("align rom_en", 32'(rom_en), 32'd1);
`endif
    step(0,0,1,32'hBFC00380,0,0);
    chk("realign pc", pc, 32'hBFC00380);
    chk("realign adel", 32'(fetch_adel), 32'd0);
    chk("realign rom_en", 32'(rom_en), 32'd1);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic        r, s, f, b;
      logic [31:0] fp, ba;
      r  = ($urandom_range(0, 63) == 0);
      s  = ($urandom_range(0, 2) == 0);
      f  = ($urandom_range(0, 15) == 0);
      b  = ($urandom_range(0, 3) == 0);
      fp = $urandom() & 32'hFFFF_FFFC;
      ba = $urandom();
      if ($urandom_range(0, 7) != 0) ba = ba & 32'hFFFF_FFFC;
      step(r, s, f, fp, b, ba);
      chk($sformatf("rnd%0d pc", i), pc, m_pc);
      chk($sformatf("rnd%0d rom_en", i), 32'(rom_en), 32'(m_rom));
      chk($sformatf("rnd%0d pend", i), 32'(pend_valid), 32'(m_pv));
      chk($sformatf("rnd%0d adel", i), 32'(fetch_adel), 32'(m_adel));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
